// File: rtl/valid_hold_pkg.sv
// Shared types and helpers for the multi-channel valid-gated sample-and-hold.
package valid_hold_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int HOLD = 0;
    localparam int SAFE = 1;

    // Watchdog counter width; at least one bit even when the watchdog is disabled.
    function automatic int cnt_width(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/slew_step.sv
// One channel: target/output registers plus the slew clamp toward the target.
module slew_step
    import valid_hold_pkg::*;
#(
    parameter int W          = 21,
    parameter int MAX_STEP   = 0,
    parameter int SAFE_VALUE = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ce,
    input  logic                i_load,
    input  logic                i_force_safe,
    input  logic signed [W-1:0] i_data,
    output logic signed [W-1:0] o_data
);

    localparam logic signed [W-1:0] SAFE_W = W'(SAFE_VALUE);
    localparam logic signed [W:0]   STEP_D = (W+1)'(MAX_STEP);
    localparam logic signed [W-1:0] STEP_W = W'(MAX_STEP);

    logic signed [W-1:0] r_target;
    logic signed [W-1:0] r_out;
    logic signed [W-1:0] w_goal;
    logic signed [W-1:0] w_target_next;
    logic signed [W-1:0] w_out_next;
    logic signed [W:0]   w_diff;

    always_comb begin
        // A latch steers this cycle's step toward the incoming sample.
        w_goal        = i_load ? i_data : r_target;
        w_target_next = i_load ? i_data : (i_force_safe ? SAFE_W : r_target);
        // One extra bit so full-scale swings cannot wrap.
        w_diff        = {w_goal[W-1], w_goal} - {r_out[W-1], r_out};
        w_out_next    = w_goal;
        if (MAX_STEP != 0) begin
            if (w_diff > STEP_D) begin
                w_out_next = r_out + STEP_W;
            end else if (w_diff < -STEP_D) begin
                w_out_next = r_out - STEP_W;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_target <= SAFE_W;
            r_out    <= SAFE_W;
        end else if (i_ce) begin
            r_target <= w_target_next;
            r_out    <= w_out_next;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/valid_hold_multi.sv
// NCH-channel sample-and-hold with clock enable, optional slew limit and a
// staleness watchdog that can fall back to a safe value.
module valid_hold_multi
    import valid_hold_pkg::*;
#(
    parameter int W              = 21,
    parameter int NCH            = 2,
    parameter int MAX_STEP       = 0,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_MODE   = 0,
    parameter int SAFE_VALUE     = 0
) (
    input  logic             clk_1,
    input  logic             rst_n_1,
    input  logic             ce_1,
    input  logic [NCH*W-1:0] in_data,
    input  logic             in_valid,
    output logic [NCH*W-1:0] out_data,
    output logic             out_valid,
    output logic             out_fresh,
    output logic             timeout_flag
);

    localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_valid;
    logic          w_latch;
    logic          w_expire;
    logic          w_force_safe;

    always_comb begin
        w_latch      = ce_1 && in_valid;
        // A latch on the expiry cycle wins, so it suppresses expiry here.
        w_expire     = (TIMEOUT_CYCLES != 0) && (r_state == RUN) &&
                       (r_cnt == CNT_LAST) && !w_latch;
        w_force_safe = w_expire && (TIMEOUT_MODE == SAFE);
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            INIT, TIMEOUT: begin
                if (w_latch) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            end
            RUN: begin
                if (w_latch) begin
                    w_cnt_next = '0;
                end else if (w_expire) begin
                    w_state_next = TIMEOUT;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n_1) begin
        if (!rst_n_1) begin
            r_state <= INIT;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_latch;
            if (ce_1) begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            slew_step #(
                .W          (W),
                .MAX_STEP   (MAX_STEP),
                .SAFE_VALUE (SAFE_VALUE)
            ) u_ch (
                .i_clk        (clk_1),
                .i_rst_n      (rst_n_1),
                .i_ce         (ce_1),
                .i_load       (w_latch),
                .i_force_safe (w_force_safe),
                .i_data       (in_data[gi*W +: W]),
                .o_data       (out_data[gi*W +: W])
            );
        end
    endgenerate

    assign out_valid    = r_valid;
    assign out_fresh    = (r_state == RUN);
    assign timeout_flag = (r_state == TIMEOUT);

endmodule
